// File: rtl/mmu_result_serializer.sv
// mmu_result_serializer
//   Buffers 128-bit MMU result rows in a small row FIFO and serializes each
//   row into LANES AXI-Stream beats (lane 0 first). m_axis_last marks the
//   final beat of every ROWS_PER_FRAME-row result frame. Rows arriving while
//   the FIFO is full are dropped and latch the sticky o_overflow flag.
//
//   Optional feature macro: SERIALIZER_DONE_INTR_EN
//     When defined, adds o_intr: a one-cycle pulse on the cycle after the
//     beat carrying m_axis_last transfers (frame-done interrupt).
//
// Ports:
//   axi_clk, axi_rst  clock; synchronous active-high reset
//   in_data/in_valid  MMU result row and its one-cycle qualifier (no stall)
//   in_ready          row FIFO has free space
//   m_axis_*          AXI-Stream master toward the DMA S2MM channel
//   o_overflow        sticky: a row was dropped because the FIFO was full
//   o_intr            frame-done pulse (only with SERIALIZER_DONE_INTR_EN)
module mmu_result_serializer #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned LANES          = 4,
  parameter int unsigned ROWS_PER_FRAME = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                      axi_clk,
  input  logic                      axi_rst,
  input  logic [DATA_W*LANES-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_W-1:0]         m_axis_data,
  output logic                      m_axis_valid,
  input  logic                      m_axis_ready,
  output logic                      m_axis_last,
  output logic                      o_overflow
`ifdef SERIALIZER_DONE_INTR_EN
  ,
  output logic                      o_intr
`endif
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned ROW_W  = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;

  typedef logic [DATA_W*LANES-1:0] row_t;

  row_t              mem_q [FIFO_DEPTH];
  row_t              mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              overflow_q, overflow_d;
`ifdef SERIALIZER_DONE_INTR_EN
  logic              intr_q, intr_d;
`endif

  logic full, wr_en, beat, pop, lane_end, row_end;
  row_t head;

  always_comb begin
    // Full is judged on the registered count only, so a pop in the same
    // cycle never makes room for that cycle's incoming row.
    full         = (count_q == CNT_W'(FIFO_DEPTH));
    in_ready     = !full;
    wr_en        = in_valid && !full;
    m_axis_valid = (count_q != '0);
    beat         = m_axis_valid && m_axis_ready;
    lane_end     = (lane_q == LANE_W'(LANES - 1));
    row_end      = (row_q == ROW_W'(ROWS_PER_FRAME - 1));
    pop          = beat && lane_end;
    m_axis_last  = m_axis_valid && lane_end && row_end;
    o_overflow   = overflow_q;

    head        = mem_q[rd_ptr_q];
    m_axis_data = '0;
    if (m_axis_valid) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (lane_q == LANE_W'(k)) m_axis_data = head[k*DATA_W +: DATA_W];
      end
    end

    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = in_data;

    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    lane_d = lane_q;
    if (beat) lane_d = lane_end ? '0 : lane_q + LANE_W'(1);

    row_d = row_q;
    if (pop) row_d = row_end ? '0 : row_q + ROW_W'(1);

    overflow_d = overflow_q || (in_valid && full);

`ifdef SERIALIZER_DONE_INTR_EN
    intr_d = beat && m_axis_last;
    o_intr = intr_q;
`endif
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lane_q     <= '0;
      row_q      <= '0;
      overflow_q <= 1'b0;
`ifdef SERIALIZER_DONE_INTR_EN
      intr_q     <= 1'b0;
`endif
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lane_q     <= lane_d;
      row_q      <= row_d;
      overflow_q <= overflow_d;
`ifdef SERIALIZER_DONE_INTR_EN
      intr_q     <= intr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mmu_result_serializer.sv
// Self-checking bench for mmu_result_serializer: a negedge monitor compares
// every transferred beat against a queue of expected {last,data} beats that
// the stimulus tasks push when rows are driven, and checks stall stability.
module tb_mmu_result_serializer;
  localparam int DW  = 32;
  localparam int LN  = 4;
  localparam int RPF = 4;
  localparam int DEP = 4;

  logic             clk = 1'b0;
  logic             axi_rst;
  logic [DW*LN-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    m_axis_data;
  logic             m_axis_valid;
  logic             m_axis_ready;
  logic             m_axis_last;
  logic             o_overflow;
`ifdef SERIALIZER_DONE_INTR_EN
  logic             o_intr;
`endif

  always #5 clk = ~clk;

  mmu_result_serializer #(
    .DATA_W(DW), .LANES(LN), .ROWS_PER_FRAME(RPF), .FIFO_DEPTH(DEP)
  ) dut (
    .axi_clk(clk),
    .axi_rst(axi_rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .m_axis_data(m_axis_data),
    .m_axis_valid(m_axis_valid),
    .m_axis_ready(m_axis_ready),
    .m_axis_last(m_axis_last),
    .o_overflow(o_overflow)
`ifdef SERIALIZER_DONE_INTR_EN
    ,
    .o_intr(o_intr)
`endif
  );

  int checks = 0;
  int fails  = 0;
  int beats  = 0;
  int lasts  = 0;
  int stalls = 0;
  int intrs  = 0;

  logic [DW:0] exp_q[$];
  int          exp_row = 0;

  // ---------------- scoreboard monitor ----------------
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [DW:0]   exp_beat;

  always @(negedge clk) begin
    if (!axi_rst) begin
      if (stall_prev) begin
        checks++;
        stalls++;
        if (m_axis_valid !== 1'b1 || m_axis_data !== prev_data || m_axis_last !== prev_last) begin
          fails++;
          $display("FAIL stall_hold: got valid=%0b data=%0d last=%0b, required valid=1 data=%0d last=%0b",
                   m_axis_valid, m_axis_data, m_axis_last, prev_data, prev_last);
        end
      end
      if (m_axis_valid && m_axis_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL beat_unexpected: got data=%0d last=%0b, required no beat", m_axis_data, m_axis_last);
        end else begin
          exp_beat = exp_q.pop_front();
          if ({m_axis_last, m_axis_data} !== exp_beat) begin
            fails++;
            $display("FAIL beat: got data=%0d last=%0b, required data=%0d last=%0b",
                     m_axis_data, m_axis_last, exp_beat[DW-1:0], exp_beat[DW]);
          end
        end
        beats++;
        if (m_axis_last) lasts++;
      end
      stall_prev = m_axis_valid && !m_axis_ready;
      prev_data  = m_axis_data;
      prev_last  = m_axis_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

`ifdef SERIALIZER_DONE_INTR_EN
  logic last_xfer_prev = 1'b0;
  always @(negedge clk) begin
    if (!axi_rst) begin
      if (o_intr === 1'b1) begin
        intrs++;
        checks++;
        if (!last_xfer_prev) begin
          fails++;
          $display("FAIL intr_timing: got o_intr=1, required o_intr only one cycle after a last beat");
        end
      end
      last_xfer_prev = m_axis_valid && m_axis_ready && m_axis_last;
    end else begin
      last_xfer_prev = 1'b0;
    end
  end
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [DW*LN-1:0] make_row(input int unsigned base);
    logic [DW*LN-1:0] r;
    for (int k = 0; k < LN; k++) r[k*DW +: DW] = DW'(base + k);
    return r;
  endfunction

  task automatic push_expected(input logic [DW*LN-1:0] row);
    logic lst;
    for (int k = 0; k < LN; k++) begin
      lst = (k == LN - 1) && (exp_row == RPF - 1);
      exp_q.push_back({lst, row[k*DW +: DW]});
    end
    exp_row = (exp_row + 1) % RPF;
  endtask

  task automatic drive_row(input logic [DW*LN-1:0] row, input bit accept);
    in_data  = row;
    in_valid = 1'b1;
    if (accept) push_expected(row);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_frame(input int unsigned base, input int unsigned stride);
    for (int r = 0; r < RPF; r++) begin
      int n = 0;
      while (!in_ready && n < 1000) begin
        @(posedge clk); #1;
        n++;
      end
      if (!in_ready) begin
        checks++;
        fails++;
        $display("FAIL in_ready_timeout: got in_ready=0, required 1 within 1000 cycles");
      end
      drive_row(make_row(base + stride * r), 1'b1);
    end
  endtask

  task automatic do_reset();
    axi_rst      = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    m_axis_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    axi_rst = 1'b0;
    exp_q.delete();
    exp_row = 0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || m_axis_valid) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || m_axis_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_drain: got %0d beats pending valid=%0b, required 0 pending valid=0",
               name, exp_q.size(), m_axis_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, m_axis_valid, m_axis_last, o_overflow} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_flags: got ready/valid/last/ovf=%b, required 1000",
               {in_ready, m_axis_valid, m_axis_last, o_overflow});
    end
    checks++;
    if (m_axis_data !== '0) begin
      fails++;
      $display("FAIL reset_data: got %0d, required 0", m_axis_data);
    end
`ifdef SERIALIZER_DONE_INTR_EN
    checks++;
    if (o_intr !== 1'b0) begin
      fails++;
      $display("FAIL reset_intr: got %0b, required 0", o_intr);
    end
`endif
  endtask

  task automatic test_single_frame();
    int b0 = beats;
    int l0 = lasts;
    m_axis_ready = 1'b1;
    send_frame(0, 16);
    wait_drain("single");
    checks++;
    if (beats - b0 != 16 || lasts - l0 != 1) begin
      fails++;
      $display("FAIL single_counts: got beats=%0d lasts=%0d, required 16 and 1", beats - b0, lasts - l0);
    end
    checks++;
    if (o_overflow !== 1'b0) begin
      fails++;
      $display("FAIL single_overflow: got %0b, required 0", o_overflow);
    end
  endtask

  task automatic test_backpressure();
    int b0 = beats;
    int l0 = lasts;
    int s0 = stalls;
    fork
      send_frame(0, 16);
      begin
        int i = 0;
        while (beats - b0 < 16 && i < 500) begin
          m_axis_ready = (i % 4 == 0) || (i % 4 == 3);
          @(posedge clk); #1;
          i++;
        end
      end
    join
    m_axis_ready = 1'b1;
    wait_drain("backpressure");
    checks++;
    if (beats - b0 != 16 || lasts - l0 != 1 || stalls - s0 == 0) begin
      fails++;
      $display("FAIL backpressure_counts: got beats=%0d lasts=%0d stalls=%0d, required 16, 1, >0",
               beats - b0, lasts - l0, stalls - s0);
    end
  endtask

  task automatic test_overflow();
    int b0 = beats;
    m_axis_ready = 1'b0;
    drive_row(make_row(200), 1'b1);
    checks++;
    if (m_axis_valid !== 1'b1 || m_axis_data !== 32'd200) begin
      fails++;
      $display("FAIL latency: got valid=%0b data=%0d, required valid=1 data=200", m_axis_valid, m_axis_data);
    end
    for (int r = 1; r < 4; r++) drive_row(make_row(200 + 16 * r), 1'b1);
    checks++;
    if (in_ready !== 1'b0 || o_overflow !== 1'b0) begin
      fails++;
      $display("FAIL full_ready: got in_ready=%0b ovf=%0b, required 0 and 0", in_ready, o_overflow);
    end
    drive_row(make_row(264), 1'b0);
    checks++;
    if (o_overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_set: got %0b, required 1", o_overflow);
    end
    m_axis_ready = 1'b1;
    wait_drain("overflow");
    checks++;
    if (beats - b0 != 16 || o_overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_drain: got beats=%0d ovf=%0b, required 16 and 1", beats - b0, o_overflow);
    end
  endtask

  task automatic test_full_pop();
    int b0;
    do_reset();
    b0 = beats;
    for (int r = 0; r < 4; r++) drive_row(make_row(400 + 16 * r), 1'b1);
    m_axis_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || m_axis_data !== 32'd403) begin
      fails++;
      $display("FAIL fullpop_pre: got in_ready=%0b data=%0d, required 0 and 403", in_ready, m_axis_data);
    end
    in_data  = make_row(999);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid     = 1'b0;
    in_data      = '0;
    m_axis_ready = 1'b0;
    checks++;
    if (o_overflow !== 1'b1 || in_ready !== 1'b1 || m_axis_data !== 32'd416) begin
      fails++;
      $display("FAIL fullpop_post: got ovf=%0b in_ready=%0b data=%0d, required 1, 1, 416",
               o_overflow, in_ready, m_axis_data);
    end
    m_axis_ready = 1'b1;
    wait_drain("fullpop");
    checks++;
    if (beats - b0 != 16) begin
      fails++;
      $display("FAIL fullpop_beats: got %0d, required 16", beats - b0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int b0 = beats;
    int b1;
    int l1;
    int n = 0;
    m_axis_ready = 1'b1;
    send_frame(500, 16);
    while (beats - b0 < 6 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    axi_rst      = 1'b1;
    m_axis_ready = 1'b0;
    @(posedge clk); #1;
    axi_rst = 1'b0;
    exp_q.delete();
    exp_row = 0;
    checks++;
    if (m_axis_valid !== 1'b0 || m_axis_data !== '0 || m_axis_last !== 1'b0 || o_overflow !== 1'b0) begin
      fails++;
      $display("FAIL midreset_state: got valid=%0b data=%0d last=%0b ovf=%0b, required all 0",
               m_axis_valid, m_axis_data, m_axis_last, o_overflow);
    end
    b1 = beats;
    l1 = lasts;
    m_axis_ready = 1'b1;
    drive_row(make_row(100), 1'b1);
    checks++;
    if (m_axis_data !== 32'd100) begin
      fails++;
      $display("FAIL midreset_first: got %0d, required 100", m_axis_data);
    end
    for (int r = 1; r < 4; r++) drive_row(make_row(100 + 4 * r), 1'b1);
    wait_drain("midreset");
    checks++;
    if (beats - b1 != 16 || lasts - l1 != 1 || o_overflow !== 1'b0) begin
      fails++;
      $display("FAIL midreset_counts: got beats=%0d lasts=%0d ovf=%0b, required 16, 1, 0",
               beats - b1, lasts - l1, o_overflow);
    end
  endtask

  task automatic test_back_to_back();
    int b0 = beats;
    int l0 = lasts;
    int i0 = intrs;
    m_axis_ready = 1'b1;
    send_frame(600, 16);
    send_frame(700, 16);
    wait_drain("b2b");
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (beats - b0 != 32 || lasts - l0 != 2) begin
      fails++;
      $display("FAIL b2b_counts: got beats=%0d lasts=%0d, required 32 and 2", beats - b0, lasts - l0);
    end
`ifdef SERIALIZER_DONE_INTR_EN
    checks++;
    if (intrs - i0 != 2) begin
      fails++;
      $display("FAIL b2b_intr: got %0d pulses, required 2", intrs - i0);
    end
`else
    checks++;
    if (intrs - i0 != 0) begin
      fails++;
      $display("FAIL b2b_intr: got %0d pulses, required 0", intrs - i0);
    end
`endif
  endtask

  initial begin
    axi_rst      = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    m_axis_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
